// File: rtl/dfr_pkg.sv
// dfr_pkg: shared state encoding and datapath widths for the reservoir sequencer
package dfr_pkg;
  localparam int DW  = 16;
  localparam int MGW = 32;
  typedef enum logic [2:0] {
    IDLE, CLEAR, WAIT_SAMPLE, READ, CALC, WRITE, OUT, DONE
  } state_t;
endpackage

// File: rtl/dfr_node_input_calc.sv
// dfr_node_input_calc: masked sample plus previous node state, saturated to the LUT input width
module dfr_node_input_calc import dfr_pkg::*; #(
  parameter int FRAC_BITS = 16
) (
  input  logic [DW-1:0] sample,
  input  logic [DW-1:0] mask,
  input  logic [DW-1:0] prev,
  output logic [DW-1:0] sat
);
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   j;
  logic [DW:0]     sum;
  assign prod = (2*DW)'(sample) * (2*DW)'(mask);
  assign j    = DW'(prod >> FRAC_BITS);
  assign sum  = {1'b0, j} + {1'b0, prev};
  assign sat  = sum[DW] ? '1 : sum[DW-1:0];
endmodule

// File: rtl/dfr_reservoir_sequencer.sv
// dfr_reservoir_sequencer: walks the virtual nodes through the shared Mackey-Glass LUT per input sample
module dfr_reservoir_sequencer import dfr_pkg::*; #(
  parameter int NODE_W    = 8,
  parameter int CNT_W     = 16,
  parameter int FRAC_BITS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear_state,
  input  logic [NODE_W:0]   num_nodes,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DW-1:0]     sample_data,
  output logic [NODE_W-1:0] mask_addr,
  input  logic [DW-1:0]     mask_data,
  output logic [NODE_W-1:0] res_addr,
  input  logic [DW-1:0]     res_rd_data,
  output logic              res_wr_en,
  output logic [DW-1:0]     res_wr_data,
  output logic [MGW-1:0]    mg_din,
  input  logic [MGW-1:0]    mg_dout,
  output logic              node_valid,
  input  logic              node_ready,
  output logic [DW-1:0]     node_data,
  output logic              node_last,
  output logic              busy,
  output logic              done
);
  state_t            state_q, state_d;
  logic [NODE_W-1:0] idx_q, idx_d;
  logic [NODE_W:0]   nn_q, nn_d;
  logic [CNT_W-1:0]  ns_q, ns_d, cnt_q, cnt_d;
  logic [DW-1:0]     smp_q, smp_d;
  logic [DW-1:0]     sat;
  logic              last, zero_start;
  logic              sample_ready_q, sample_ready_d, busy_q, busy_d, done_q, done_d;
  logic              res_wr_en_q, res_wr_en_d, node_valid_q, node_valid_d, node_last_q, node_last_d;
  logic [NODE_W-1:0] mask_addr_q, mask_addr_d, res_addr_q, res_addr_d;
  logic [MGW-1:0]    mg_din_q, mg_din_d;
  logic [DW-1:0]     node_data_q, node_data_d;
  logic              unused_mg;

  dfr_node_input_calc #(.FRAC_BITS(FRAC_BITS)) u_calc (
    .sample(smp_q),
    .mask  (mask_data),
    .prev  (res_rd_data),
    .sat   (sat)
  );

  assign last         = {1'b0, idx_q} == nn_q - (NODE_W+1)'(1);
  assign unused_mg    = ^mg_dout[MGW-1:DW];
  assign res_wr_data  = (state_q == WRITE) ? mg_dout[DW-1:0] : '0;
  assign sample_ready = sample_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign res_wr_en    = res_wr_en_q;
  assign mask_addr    = mask_addr_q;
  assign res_addr     = res_addr_q;
  assign mg_din       = mg_din_q;
  assign node_valid   = node_valid_q;
  assign node_data    = node_data_q;
  assign node_last    = node_last_q;

  // next state, counters and the outputs registered for the state being entered
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    nn_d        = nn_q;
    ns_d        = ns_q;
    cnt_d       = cnt_q;
    smp_d       = smp_q;
    mg_din_d    = mg_din_q;
    node_data_d = node_data_q;
    node_valid_d = node_valid_q;
    node_last_d = node_last_q;
    zero_start  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (num_nodes == '0 || num_samples == '0) zero_start = 1'b1;
        else begin
          nn_d    = num_nodes;
          ns_d    = num_samples;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = clear_state ? CLEAR : WAIT_SAMPLE;
        end
      end
      CLEAR: begin
        idx_d   = last ? '0 : idx_q + NODE_W'(1);
        state_d = last ? WAIT_SAMPLE : CLEAR;
      end
      WAIT_SAMPLE: if (sample_valid) begin
        smp_d   = sample_data;
        idx_d   = '0;
        state_d = READ;
      end
      READ: state_d = CALC;
      CALC: begin
        mg_din_d = {{(MGW-DW){1'b0}}, sat};
        state_d  = WRITE;
      end
      WRITE: begin
        node_data_d  = mg_dout[DW-1:0];
        node_valid_d = 1'b1;
        node_last_d  = last;
        state_d      = OUT;
      end
      OUT: if (node_ready) begin
        node_valid_d = 1'b0;
        node_last_d  = 1'b0;
        if (!last) begin
          idx_d   = idx_q + NODE_W'(1);
          state_d = READ;
        end else if (cnt_q < ns_q - CNT_W'(1)) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = WAIT_SAMPLE;
        end else state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sample_ready_d = state_d == WAIT_SAMPLE;
    busy_d         = state_d != IDLE;
    done_d         = zero_start || state_d == DONE;
    res_wr_en_d    = state_d inside {CLEAR, WRITE};
    mask_addr_d    = (state_d == READ) ? idx_d : '0;
    res_addr_d     = (state_d inside {CLEAR, READ, WRITE}) ? idx_d : '0;
  end

  // state and output registers; reset abandons any run in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      nn_q           <= '0;
      ns_q           <= '0;
      cnt_q          <= '0;
      smp_q          <= '0;
      sample_ready_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      res_wr_en_q    <= 1'b0;
      mask_addr_q    <= '0;
      res_addr_q     <= '0;
      mg_din_q       <= '0;
      node_valid_q   <= 1'b0;
      node_data_q    <= '0;
      node_last_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      nn_q           <= nn_d;
      ns_q           <= ns_d;
      cnt_q          <= cnt_d;
      smp_q          <= smp_d;
      sample_ready_q <= sample_ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      res_wr_en_q    <= res_wr_en_d;
      mask_addr_q    <= mask_addr_d;
      res_addr_q     <= res_addr_d;
      mg_din_q       <= mg_din_d;
      node_valid_q   <= node_valid_d;
      node_data_q    <= node_data_d;
      node_last_q    <= node_last_d;
    end
  end
endmodule

// File: tb/tb_dfr_reservoir_sequencer.sv
// tb_dfr_reservoir_sequencer: directed bench with mask ROM, delay-line RAM and LUT models
module tb_dfr_reservoir_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, clear_state = 1'b0;
  logic [8:0]  num_nodes = '0;
  logic [15:0] num_samples = '0;
  logic        sample_valid = 1'b0, sample_ready;
  logic [15:0] sample_data = '0;
  logic [7:0]  mask_addr, res_addr;
  logic [15:0] mask_data = '0, res_rd_data = '0, res_wr_data;
  logic        res_wr_en;
  logic [31:0] mg_din, mg_dout;
  logic        node_valid, node_ready = 1'b1, node_last, busy, done;
  logic [15:0] node_data;
  logic [15:0] mask_rom [0:255];
  logic [15:0] ram [0:255];
  int          wr_cnt = 0;
  int          n_chk = 0, n_pass = 0;

  dfr_reservoir_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_state(clear_state),
    .num_nodes(num_nodes), .num_samples(num_samples),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
    .mask_addr(mask_addr), .mask_data(mask_data),
    .res_addr(res_addr), .res_rd_data(res_rd_data),
    .res_wr_en(res_wr_en), .res_wr_data(res_wr_data),
    .mg_din(mg_din), .mg_dout(mg_dout),
    .node_valid(node_valid), .node_ready(node_ready), .node_data(node_data),
    .node_last(node_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lut(input logic [15:0] x);
    case (x)
      16'h0000: lut = 16'h0008;
      16'h7FFF: lut = 16'h0B7D;
      16'h0008: lut = 16'h0014;
      16'h0B7D: lut = 16'h016D;
      16'hFFFF: lut = 16'h004E;
      default:  lut = x ^ 16'h5A5A;
    endcase
  endfunction

  assign mg_dout = {16'h0, lut(mg_din[15:0])};

  always @(posedge clk) begin
    if (res_wr_en) begin
      ram[res_addr] <= res_wr_data;
      wr_cnt <= wr_cnt + 1;
    end else if (!rst_n) begin
      ram[0] <= 16'hAAAA;
      ram[1] <= 16'hAAAA;
    end
    mask_data   <= mask_rom[mask_addr];
    res_rd_data <= ram[res_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic go(input logic cs, input logic [8:0] nn, input logic [15:0] ns);
    clear_state = cs;
    num_nodes   = nn;
    num_samples = ns;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
  endtask

  task automatic wait_ready(input string tg);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (sample_ready) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk({tg, "_ready_to"}, 32'(seen), 32'd1);
  endtask

  task automatic feed(input string tg, input logic [15:0] d);
    wait_ready(tg);
    sample_valid = 1'b1;
    sample_data  = d;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tg);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (node_valid) seen = 1'b1;
    end
    chk({tg, "_valid_to"}, 32'(seen), 32'd1);
  endtask

  task automatic take_node(input string tg, input logic [31:0] emg, input logic [15:0] ed, input logic el);
    wait_valid(tg);
    chk({tg, "_mg"}, mg_din, emg);
    chk({tg, "_data"}, 32'(node_data), 32'(ed));
    chk({tg, "_last"}, 32'(node_last), 32'(el));
  endtask

  task automatic wait_done(input string tg);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk({tg, "_done"}, 32'(seen), 32'd1);
    @(posedge clk); #1;
    chk({tg, "_done_once"}, 32'(done), 32'd0);
    chk({tg, "_busy_fall"}, 32'(busy), 32'd0);
  endtask

  task automatic run_t1(input string tg);
    mask_rom[0] = 16'h0000;
    mask_rom[1] = 16'hFFFF;
    go(1'b1, 9'd2, 16'd2);
    chk({tg, "_clr_busy"}, 32'(busy), 32'd1);
    chk({tg, "_clr_we0"}, 32'(res_wr_en), 32'd1);
    chk({tg, "_clr_a0"}, 32'(res_addr), 32'd0);
    chk({tg, "_clr_d0"}, 32'(res_wr_data), 32'd0);
    @(posedge clk); #1;
    chk({tg, "_clr_we1"}, 32'(res_wr_en), 32'd1);
    chk({tg, "_clr_a1"}, 32'(res_addr), 32'd1);
    @(posedge clk); #1;
    chk({tg, "_clr_end_we"}, 32'(res_wr_en), 32'd0);
    chk({tg, "_ram0_clr"}, 32'(ram[0]), 32'd0);
    chk({tg, "_ram1_clr"}, 32'(ram[1]), 32'd0);
    feed({tg, "_s1"}, 16'h8000);
    take_node({tg, "_s1n0"}, 32'h0000_0000, 16'h0008, 1'b0);
    take_node({tg, "_s1n1"}, 32'h0000_7FFF, 16'h0B7D, 1'b1);
    feed({tg, "_s2"}, 16'h0000);
    take_node({tg, "_s2n0"}, 32'h0000_0008, 16'h0014, 1'b0);
    take_node({tg, "_s2n1"}, 32'h0000_0B7D, 16'h016D, 1'b1);
    wait_done(tg);
    chk({tg, "_ram0"}, 32'(ram[0]), 32'h0014);
    chk({tg, "_ram1"}, 32'(ram[1]), 32'h016D);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w0;
    for (int i = 0; i < 256; i++) mask_rom[i] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(sample_ready), 0);
    chk("rst_we", 32'(res_wr_en), 0);
    chk("rst_valid", 32'(node_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mg", mg_din, 0);
    chk("rst_addrs", {16'h0, mask_addr, res_addr}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_t1("t1");

    mask_rom[0] = 16'hFFFF;
    go(1'b0, 9'd1, 16'd1);
    feed("t2_s", 16'hFFFF);
    take_node("t2_n0", 32'h0000_FFFF, 16'h004E, 1'b1);
    wait_done("t2");
    chk("t2_ram0", 32'(ram[0]), 32'h004E);

    mask_rom[0] = 16'h0000;
    mask_rom[1] = 16'hFFFF;
    node_ready = 1'b0;
    go(1'b1, 9'd2, 16'd1);
    feed("t3_s", 16'h8000);
    wait_valid("t3_n0");
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t3_hold_valid", 32'(node_valid), 1);
      chk("t3_hold_data", 32'(node_data), 32'h0008);
      chk("t3_hold_we", 32'(res_wr_en), 0);
      chk("t3_no_read", 32'(mask_addr), 0);
    end
    chk("t3_wr_cnt", 32'(wr_cnt), 32'(w0));
    node_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_read_after_acc", 32'(mask_addr), 1);
    take_node("t3_n1", 32'h0000_7FFF, 16'h0B7D, 1'b1);
    wait_done("t3");

    w0 = wr_cnt;
    go(1'b1, 9'd0, 16'd5);
    chk("t4a_done", 32'(done), 1);
    chk("t4a_busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("t4a_done_off", 32'(done), 0);
    go(1'b1, 9'd3, 16'd0);
    chk("t4b_done", 32'(done), 1);
    chk("t4b_busy", 32'(busy), 0);
    @(posedge clk); #1;
    chk("t4b_done_off", 32'(done), 0);
    chk("t4_no_write", 32'(wr_cnt), 32'(w0));

    go(1'b1, 9'd2, 16'd2);
    wait_ready("t5");
    go(1'b1, 9'd1, 16'd1);
    chk("t5_restart_ready", 32'(sample_ready), 1);
    chk("t5_restart_busy", 32'(busy), 1);
    feed("t5_s", 16'h8000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_ready", 32'(sample_ready), 0);
    chk("t5_rst_mg", mg_din, 0);
    chk("t5_rst_addrs", {16'h0, mask_addr, res_addr}, 0);
    chk("t5_rst_flags", {28'h0, res_wr_en, node_valid, node_last, done}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_t1("t5b");

    mask_rom[0] = 16'h0000;
    go(1'b0, 9'd1, 16'd1);
    wait_ready("t6");
    w0 = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t6_ready", 32'(sample_ready), 1);
      chk("t6_busy", 32'(busy), 1);
    end
    chk("t6_no_write", 32'(wr_cnt), 32'(w0));
    feed("t6_s", 16'h0000);
    take_node("t6_n0", 32'h0000_0014, 16'h5A4E, 1'b1);
    wait_done("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
